// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired control unit. Steps through fetch/decode/execute and
//            emits the datapath strobes for the current step, IR opcode and
//            branch condition.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int STEP_W = 3,
  parameter int OP_W   = 5
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        R15in,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        memRead,
  output logic        ramEnable,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        IRin,
  output logic        Cout,
  output logic        CONin,
  output logic        InPort_Out,
  output logic        OutPort_In,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR
);

  // Step encodings T0..T7
  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
  localparam logic [STEP_W-1:0] T5 = STEP_W'(5);
  localparam logic [STEP_W-1:0] T6 = STEP_W'(6);
  localparam logic [STEP_W-1:0] T7 = STEP_W'(7);

  // Opcodes
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(13);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(21);
  localparam logic [OP_W-1:0] OP_IN   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_OUT  = OP_W'(23);
  localparam logic [OP_W-1:0] OP_MFHI = OP_W'(24);
  localparam logic [OP_W-1:0] OP_MFLO = OP_W'(25);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, r15in;
    logic pcout, pcin, incpc, marin, mdrin, mdrout, memread, ramenable;
    logic yin, zin, zlowout, zhighout, hiout, loout, irin, cout, conin;
    logic inport_out, outport_in, alu_add, alu_sub, alu_and, alu_or;
  } ctrl_t;

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic              run_q, run_d;
  logic [OP_W-1:0]   op;
  logic              last_step;
  logic              is_imm;
  ctrl_t             ctrl_raw;
  ctrl_t             ctrl;

  // Register fields are decoded by the datapath's select/encode logic, not here
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[31-OP_W:0];

  assign op     = IR[31 -: OP_W];
  assign is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);

  // Strobe decode for the current step; last_step marks the final step of an instruction
  always_comb begin
    ctrl_raw  = '0;
    last_step = 1'b0;
    case (step_q)
      T0: begin
        ctrl_raw.pcout = 1'b1;
        ctrl_raw.marin = 1'b1;
        ctrl_raw.incpc = 1'b1;
      end
      T1: begin
        ctrl_raw.memread = 1'b1;
        ctrl_raw.mdrin   = 1'b1;
      end
      T2: begin
        ctrl_raw.mdrout = 1'b1;
        ctrl_raw.irin   = 1'b1;
      end
      default: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            case (step_q)
              T3: begin
                ctrl_raw.grb   = 1'b1;
                ctrl_raw.baout = 1'b1;
                ctrl_raw.yin   = 1'b1;
              end
              T4: begin
                ctrl_raw.cout    = 1'b1;
                ctrl_raw.alu_add = 1'b1;
                ctrl_raw.zin     = 1'b1;
              end
              T5: begin
                ctrl_raw.zlowout = 1'b1;
                if (op == OP_LDI) begin
                  ctrl_raw.gra = 1'b1;
                  ctrl_raw.rin = 1'b1;
                  last_step    = 1'b1;
                end else begin
                  ctrl_raw.marin = 1'b1;
                end
              end
              T6: begin
                ctrl_raw.mdrin = 1'b1;
                if (op == OP_LD) begin
                  ctrl_raw.memread = 1'b1;
                end else begin
                  ctrl_raw.gra  = 1'b1;
                  ctrl_raw.rout = 1'b1;
                end
              end
              T7: begin
                if (op == OP_LD) begin
                  ctrl_raw.mdrout = 1'b1;
                  ctrl_raw.gra    = 1'b1;
                  ctrl_raw.rin    = 1'b1;
                end else begin
                  ctrl_raw.ramenable = 1'b1;
                end
                last_step = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step_q)
              T3: begin
                ctrl_raw.grb  = 1'b1;
                ctrl_raw.rout = 1'b1;
                ctrl_raw.yin  = 1'b1;
              end
              T4: begin
                // Immediate forms take the second operand from the C field
                if (is_imm) begin
                  ctrl_raw.cout = 1'b1;
                end else begin
                  ctrl_raw.grc  = 1'b1;
                  ctrl_raw.rout = 1'b1;
                end
                ctrl_raw.zin     = 1'b1;
                ctrl_raw.alu_add = (op == OP_ADD) || (op == OP_ADDI);
                ctrl_raw.alu_sub = (op == OP_SUB);
                ctrl_raw.alu_and = (op == OP_AND) || (op == OP_ANDI);
                ctrl_raw.alu_or  = (op == OP_OR)  || (op == OP_ORI);
              end
              T5: begin
                ctrl_raw.zlowout = 1'b1;
                ctrl_raw.gra     = 1'b1;
                ctrl_raw.rin     = 1'b1;
                last_step        = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_BR: begin
            case (step_q)
              T3: begin
                ctrl_raw.gra   = 1'b1;
                ctrl_raw.rout  = 1'b1;
                ctrl_raw.conin = 1'b1;
              end
              T4: begin
                ctrl_raw.pcout = 1'b1;
                ctrl_raw.yin   = 1'b1;
              end
              T5: begin
                ctrl_raw.cout    = 1'b1;
                ctrl_raw.alu_add = 1'b1;
                ctrl_raw.zin     = 1'b1;
              end
              T6: begin
                // Branch target is only committed when the condition holds
                ctrl_raw.zlowout = CON;
                ctrl_raw.pcin    = CON;
                last_step        = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_JR: begin
            ctrl_raw.gra  = 1'b1;
            ctrl_raw.rout = 1'b1;
            ctrl_raw.pcin = 1'b1;
            last_step     = 1'b1;
          end
          OP_JAL: begin
            if (step_q == T3) begin
              ctrl_raw.pcout = 1'b1;
              ctrl_raw.r15in = 1'b1;
            end else begin
              ctrl_raw.gra  = 1'b1;
              ctrl_raw.rout = 1'b1;
              ctrl_raw.pcin = 1'b1;
              last_step     = 1'b1;
            end
          end
          OP_IN: begin
            ctrl_raw.inport_out = 1'b1;
            ctrl_raw.gra        = 1'b1;
            ctrl_raw.rin        = 1'b1;
            last_step           = 1'b1;
          end
          OP_OUT: begin
            ctrl_raw.gra        = 1'b1;
            ctrl_raw.rout       = 1'b1;
            ctrl_raw.outport_in = 1'b1;
            last_step           = 1'b1;
          end
          OP_MFHI: begin
            ctrl_raw.hiout = 1'b1;
            ctrl_raw.gra   = 1'b1;
            ctrl_raw.rin   = 1'b1;
            last_step      = 1'b1;
          end
          OP_MFLO: begin
            ctrl_raw.loout = 1'b1;
            ctrl_raw.gra   = 1'b1;
            ctrl_raw.rin   = 1'b1;
            last_step      = 1'b1;
          end
          OP_HALT: last_step = 1'b0;
          default: last_step = 1'b1;
        endcase
      end
    endcase
  end

  // Next-state: halt freezes the step counter, otherwise advance or wrap to T0
  always_comb begin
    halted_d = halted_q || ((step_q == T3) && (op == OP_HALT));
    run_d    = !halted_d;
    if (halted_d) begin
      step_d = step_q;
    end else if (last_step) begin
      step_d = T0;
    end else begin
      step_d = step_q + STEP_W'(1);
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      run_q    <= run_d;
    end
  end

  // Strobes are silenced while clear is held and once halted
  assign ctrl = (clear_n && !halted_q) ? ctrl_raw : '0;
  assign run  = run_q && clear_n;

  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Rin        = ctrl.rin;
  assign Rout       = ctrl.rout;
  assign BAout      = ctrl.baout;
  assign R15in      = ctrl.r15in;
  assign PCout      = ctrl.pcout;
  assign PCin       = ctrl.pcin;
  assign IncPC      = ctrl.incpc;
  assign MARin      = ctrl.marin;
  assign MDRin      = ctrl.mdrin;
  assign MDRout     = ctrl.mdrout;
  assign memRead    = ctrl.memread;
  assign ramEnable  = ctrl.ramenable;
  assign Yin        = ctrl.yin;
  assign Zin        = ctrl.zin;
  assign Zlowout    = ctrl.zlowout;
  assign Zhighout   = ctrl.zhighout;
  assign HIout      = ctrl.hiout;
  assign LOout      = ctrl.loout;
  assign IRin       = ctrl.irin;
  assign Cout       = ctrl.cout;
  assign CONin      = ctrl.conin;
  assign InPort_Out = ctrl.inport_out;
  assign OutPort_In = ctrl.outport_in;
  assign ADD        = ctrl.alu_add;
  assign SUB        = ctrl.alu_sub;
  assign AND        = ctrl.alu_and;
  assign OR         = ctrl.alu_or;

endmodule
`default_nettype wire
